// File: rtl/parking_input_timebase.sv
// Input conditioning, time base and visit token issue for the parking access FSM.
// Raw inputs are synchronised, TimeData counts prescaled ticks, and each visit draws a token from a 3-bit LFSR.
module parking_input_timebase #(
    parameter int unsigned TICK_DIV  = 1000,
    parameter logic [2:0]  LFSR_SEED = 3'b101
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       request_raw,
    input  logic       confirm_btn,
    input  logic       time_load,
    input  logic [7:0] time_load_value,
    output logic       request,
    output logic       confirm,
    output logic [7:0] TimeData,
    output logic [2:0] system_token,
    output logic       token_valid,
    output logic       tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic             req_s1;
    logic             cfm_s1;
    logic             cfm_s2;
    logic             cfm_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       lfsr;
    state_t           state;
    state_t           state_nxt;
    logic [2:0]       token_nxt;
    logic             valid_nxt;

    // Two-flop synchronisers; confirm fires on the synced rising edge and is
    // suppressed when request is low now or is about to drop on this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_s1  <= 1'b0;
            request <= 1'b0;
            cfm_s1  <= 1'b0;
            cfm_s2  <= 1'b0;
            cfm_d   <= 1'b0;
            confirm <= 1'b0;
        end else begin
            req_s1  <= request_raw;
            request <= req_s1;
            cfm_s1  <= confirm_btn;
            cfm_s2  <= cfm_s1;
            cfm_d   <= cfm_s2;
            confirm <= cfm_s2 & ~cfm_d & request & req_s1;
        end
    end

    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (time_load || (cnt == CNT_MAX)) begin
            cnt_nxt = '0;
        end
    end

    // tick is registered from the next count so it is high while cnt == TICK_DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            tick     <= 1'b0;
            TimeData <= 8'h00;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == CNT_MAX);
            if (time_load) begin
                TimeData <= time_load_value;
            end else if (tick) begin
                TimeData <= TimeData + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            system_token <= 3'b000;
            token_valid  <= 1'b0;
        end else begin
            state        <= state_nxt;
            system_token <= token_nxt;
            token_valid  <= valid_nxt;
        end
    end

    // Token FSM: a token is captured in ISSUE and frozen until request drops.
    always_comb begin
        state_nxt = state;
        token_nxt = system_token;
        valid_nxt = token_valid;
        case (state)
            ST_IDLE: begin
                token_nxt = 3'b000;
                valid_nxt = 1'b0;
                if (request) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (request) begin
                    state_nxt = ST_HOLD;
                    token_nxt = lfsr;
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    token_nxt = 3'b000;
                    valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!request) begin
                    state_nxt = ST_IDLE;
                    token_nxt = 3'b000;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                token_nxt = 3'b000;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_parking_input_timebase.sv
// Directed bench for parking_input_timebase with TICK_DIV = 4.
module tb_parking_input_timebase;

    logic       clock;
    logic       reset;
    logic       request_raw;
    logic       confirm_btn;
    logic       time_load;
    logic [7:0] time_load_value;
    logic       request;
    logic       confirm;
    logic [7:0] TimeData;
    logic [2:0] system_token;
    logic       token_valid;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    parking_input_timebase #(.TICK_DIV(4), .LFSR_SEED(3'b101)) dut (
        .clock           (clock),
        .reset           (reset),
        .request_raw     (request_raw),
        .confirm_btn     (confirm_btn),
        .time_load       (time_load),
        .time_load_value (time_load_value),
        .request         (request),
        .confirm         (confirm),
        .TimeData        (TimeData),
        .system_token    (system_token),
        .token_valid     (token_valid),
        .tick            (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges seen since reset release; the expected LFSR value is a table lookup on it.
    always @(posedge clock or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [2:0] lfsr_expect(input int n);
        logic [2:0] seq [7];
        seq = '{3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010};
        return seq[n % 7];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " request"},      32'(request),      32'd0);
        chk({tag, " confirm"},      32'(confirm),      32'd0);
        chk({tag, " tick"},         32'(tick),         32'd0);
        chk({tag, " TimeData"},     32'(TimeData),     32'h00);
        chk({tag, " system_token"}, 32'(system_token), 32'd0);
        chk({tag, " token_valid"},  32'(token_valid),  32'd0);
    endtask

    // Raise request and check the captured token against the seeded LFSR sequence.
    task automatic start_visit(input string tag, output logic [2:0] tok);
        request_raw = 1'b1;
        step();
        chk({tag, " request after 1"}, 32'(request), 32'd0);
        step();
        chk({tag, " request after 2"}, 32'(request), 32'd1);
        step();
        tok = lfsr_expect(edges);
        chk({tag, " valid in ISSUE"}, 32'(token_valid), 32'd0);
        step();
        chk({tag, " token"},       32'(system_token), 32'(tok));
        chk({tag, " token_valid"}, 32'(token_valid),  32'd1);
        chk({tag, " token nonzero"}, 32'(system_token != 3'b000), 32'd1);
    endtask

    typedef struct {
        logic       load;
        logic [7:0] value;
        logic       exp_tick;
        logic [7:0] exp_time;
    } vec_t;

    initial begin
        vec_t       vecs [17];
        logic [2:0] tok;
        int         pulses;
        int         pulse_at;

        reset           = 1'b1;
        request_raw     = 1'b0;
        confirm_btn     = 1'b0;
        time_load       = 1'b0;
        time_load_value = 8'h00;

        vecs[0]  = '{1'b1, 8'hFE, 1'b0, 8'hFE};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'hFE};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'hFE};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'hFE};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'hFF};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'hFF};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'hFF};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'hFF};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h00};
        vecs[12] = '{1'b1, 8'h3C, 1'b0, 8'h3C};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h3C};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h3C};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 8'h3C};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 8'h3D};

        repeat (3) step();
        chk_reset_values("reset");
        reset = 1'b0;

        // Prescaler/TimeData table; vector 12 loads while tick is high.
        for (int i = 0; i < 17; i++) begin
            time_load       = vecs[i].load;
            time_load_value = vecs[i].value;
            step();
            chk($sformatf("vec%0d tick", i),     32'(tick),     32'(vecs[i].exp_tick));
            chk($sformatf("vec%0d TimeData", i), 32'(TimeData), 32'(vecs[i].exp_time));
        end
        time_load = 1'b0;

        start_visit("visit1", tok);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("frozen token c%0d", i), 32'({token_valid, system_token}), 32'({1'b1, tok}));
        end

        // Held confirm button during HOLD: one pulse, on the third edge.
        confirm_btn = 1'b1;
        pulses   = 0;
        pulse_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (confirm) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        chk("confirm pulse count", 32'(pulses), 32'd1);
        chk("confirm pulse latency", 32'(pulse_at), 32'd3);
        confirm_btn = 1'b0;
        repeat (3) step();

        // Drop request during HOLD.
        request_raw = 1'b0;
        step();
        chk("drop request after 1", 32'(request), 32'd1);
        step();
        chk("drop request after 2", 32'(request), 32'd0);
        chk("drop token still live", 32'({token_valid, system_token}), 32'({1'b1, tok}));
        step();
        chk("drop token cleared", 32'(system_token), 32'd0);
        chk("drop valid cleared", 32'(token_valid), 32'd0);

        // Same press with request low: no pulse.
        confirm_btn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (confirm) pulses++;
        end
        chk("confirm gated by request", 32'(pulses), 32'd0);
        confirm_btn = 1'b0;
        repeat (3) step();

        start_visit("visit2", tok);
        repeat (5) step();

        // Asynchronous reset mid-visit.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("midreset");
        step();
        step();
        chk("midreset held token", 32'(system_token), 32'd0);
        reset = 1'b0;
        start_visit("visit3", tok);

        request_raw = 1'b0;
        repeat (4) step();
        chk("final idle valid", 32'(token_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
